// File: rtl/decode_stage_pkg.sv
// Shared encodings and types for the decode stage.
// Opcodes, control field values and FSM state.
package decode_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_DPIMM  = 7'b0010011;
  localparam logic [6:0] OP_DPREG  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [1:0] PCS_NONE = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JAL  = 2'b10;
  localparam logic [1:0] PCS_JALR = 2'b11;

  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_I = 3'b011;
  localparam logic [2:0] IMM_S = 3'b110;
  localparam logic [2:0] IMM_B = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_ZERO = 2'b01;
  localparam logic [1:0] SRCA_PC   = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    RUN,
    MC_START,
    MC_WAIT
  } state_t;

  typedef struct packed {
    logic [1:0] pcs;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       compute_sel;
    logic       mcycle_sel;
    logic [1:0] mcycle_op;
    logic [2:0] size_sel;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  // mul/div unit op: bit1 picks divide, bit0 picks unsigned
  function automatic logic [1:0] mcycle_op(
    input logic [2:0] f3
  );
    return {f3[2], f3[2] ? f3[0] : f3[1]};
  endfunction

  // 0 selects the low product / quotient, 1 the other half
  function automatic logic mcycle_sel(
    input logic [2:0] f3
  );
    return !((f3 == 3'b000) ||
             (f3 == 3'b100) ||
             (f3 == 3'b101));
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and control-bundle bus of the decode stage.
// master drives instructions, slave is the stage.
interface decode_stage_if;

  logic [31:0] InstrIn;
  logic        InValid;
  logic        InReady;
  logic        OutValid;
  logic        OutReady;
  logic        Flush;

  logic [1:0]  PCS;
  logic        RegWrite;
  logic        MemWrite;
  logic        MemtoReg;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        ComputeResultSel;
  logic        MCycleResultSel;
  logic [1:0]  MCycleOp;
  logic [2:0]  SizeSel;
  logic        Illegal;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;

  logic        MCycleStart;
  logic        MCycleBusy;

  modport master (
    output InstrIn, InValid, OutReady,
    output Flush, MCycleBusy,
    input  InReady, OutValid, MCycleStart,
    input  PCS, RegWrite, MemWrite, MemtoReg,
    input  ALUSrcA, ALUSrcB, ImmSrc,
    input  ALUControl, ComputeResultSel,
    input  MCycleResultSel, MCycleOp,
    input  SizeSel, Illegal, Rd, Rs1, Rs2
  );

  modport slave (
    input  InstrIn, InValid, OutReady,
    input  Flush, MCycleBusy,
    output InReady, OutValid, MCycleStart,
    output PCS, RegWrite, MemWrite, MemtoReg,
    output ALUSrcA, ALUSrcB, ImmSrc,
    output ALUControl, ComputeResultSel,
    output MCycleResultSel, MCycleOp,
    output SizeSel, Illegal, Rd, Rs1, Rs2
  );

endinterface

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M) instruction decoder.
// Produces the full control bundle for one word.
module rv_decode_comb
  import decode_stage_pkg::*;
#(
  parameter int M_EXT      = 1,
  parameter int SUBWORD_EN = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic is_load;
  logic is_store;
  logic is_dpimm;
  logic is_dpreg;
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic is_auipc;
  logic is_lui;
  logic is_mext;
  logic shift_imm;
  logic size_ok;
  logic mext_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_dpimm  = (opcode == OP_DPIMM);
  assign is_dpreg  = (opcode == OP_DPREG);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_lui    = (opcode == OP_LUI);

  assign is_mext = is_dpreg &&
                   (funct7 == F7_MEXT);

  assign shift_imm = (funct3 == 3'b001) ||
                     (funct3 == 3'b101);

  assign size_ok = (SUBWORD_EN != 0) ||
                   (funct3 == SIZE_WORD);

  assign mext_ok = (M_EXT != 0);

  // Field decode; unmatched or disabled forms fall to illegal
  always_comb begin
    ctrl          = '0;
    ctrl.pcs      = PCS_NONE;
    ctrl.alu_ctrl = ALU_ADD;
    ctrl.size_sel = SIZE_WORD;
    ctrl.rd       = instr[11:7];
    ctrl.rs1      = instr[19:15];
    ctrl.rs2      = instr[24:20];
    unique case (1'b1)
      is_load && size_ok: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.src_b      = SRCB_IMM;
        ctrl.imm_src    = IMM_I;
        ctrl.size_sel   = funct3;
      end
      is_store && size_ok: begin
        ctrl.mem_write = 1'b1;
        ctrl.src_b     = SRCB_IMM;
        ctrl.imm_src   = IMM_S;
        ctrl.size_sel  = funct3;
      end
      is_dpimm: begin
        ctrl.reg_write = 1'b1;
        ctrl.src_b     = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_ctrl  = shift_imm ?
                         {funct3, funct7[5]} :
                         {funct3, 1'b0};
      end
      is_dpreg && !is_mext: begin
        ctrl.reg_write = 1'b1;
        ctrl.src_b     = SRCB_RS2;
        ctrl.alu_ctrl  = {funct3, funct7[5]};
      end
      is_mext && mext_ok: begin
        ctrl.reg_write   = 1'b1;
        ctrl.src_b       = SRCB_RS2;
        ctrl.alu_ctrl    = {funct3, funct7[5]};
        ctrl.compute_sel = 1'b1;
        ctrl.mcycle_op   = mcycle_op(funct3);
        ctrl.mcycle_sel  = mcycle_sel(funct3);
      end
      is_branch: begin
        ctrl.pcs      = PCS_BR;
        ctrl.imm_src  = IMM_B;
        ctrl.alu_ctrl = ALU_SUB;
      end
      is_jal: begin
        ctrl.pcs       = PCS_JAL;
        ctrl.reg_write = 1'b1;
        ctrl.src_a     = SRCA_PC;
        ctrl.src_b     = SRCB_FOUR;
        ctrl.imm_src   = IMM_J;
      end
      is_jalr: begin
        ctrl.pcs       = PCS_JALR;
        ctrl.reg_write = 1'b1;
        ctrl.src_a     = SRCA_PC;
        ctrl.src_b     = SRCB_FOUR;
        ctrl.imm_src   = IMM_I;
      end
      is_auipc: begin
        ctrl.reg_write = 1'b1;
        ctrl.src_a     = SRCA_PC;
        ctrl.src_b     = SRCB_IMM;
        ctrl.imm_src   = IMM_U;
      end
      is_lui: begin
        ctrl.reg_write = 1'b1;
        ctrl.src_a     = SRCA_ZERO;
        ctrl.src_b     = SRCB_IMM;
        ctrl.imm_src   = IMM_U;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: bundle register, handshake,
// and the issue FSM for the multicycle mul/div unit.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int M_EXT      = 1,
  parameter int SUBWORD_EN = 1
) (
  input logic           CLK,
  input logic           RESETn,
  decode_stage_if.slave bus
);

  ctrl_t  dec;
  ctrl_t  held;
  logic   out_valid;
  logic   in_ready;
  logic   accept;
  logic   xfer;
  logic   mc_start;
  state_t state;
  state_t state_nxt;

  rv_decode_comb #(
    .M_EXT      (M_EXT),
    .SUBWORD_EN (SUBWORD_EN)
  ) u_dec (
    .instr (bus.InstrIn),
    .ctrl  (dec)
  );

  assign in_ready = (state == RUN) &&
                    !bus.Flush &&
                    (!out_valid || bus.OutReady);

  assign accept = bus.InValid && in_ready;
  assign xfer   = out_valid && bus.OutReady;

  // Bundle register; flush wins over a new load
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else begin
      if (accept) begin
        held <= dec;
      end
      if (bus.Flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Issue FSM state register
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue FSM; flush never aborts an issued op
  always_comb begin
    state_nxt = state;
    mc_start  = 1'b0;
    unique case (state)
      RUN: begin
        if (xfer &&
            held.compute_sel &&
            !held.illegal) begin
          state_nxt = MC_START;
        end
      end
      MC_START: begin
        mc_start  = 1'b1;
        state_nxt = MC_WAIT;
      end
      MC_WAIT: begin
        if (!bus.MCycleBusy) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign bus.InReady     = in_ready;
  assign bus.OutValid    = out_valid;
  assign bus.MCycleStart = mc_start;

  assign bus.PCS              = held.pcs;
  assign bus.RegWrite         = held.reg_write;
  assign bus.MemWrite         = held.mem_write;
  assign bus.MemtoReg         = held.mem_to_reg;
  assign bus.ALUSrcA          = held.src_a;
  assign bus.ALUSrcB          = held.src_b;
  assign bus.ImmSrc           = held.imm_src;
  assign bus.ALUControl       = held.alu_ctrl;
  assign bus.ComputeResultSel = held.compute_sel;
  assign bus.MCycleResultSel  = held.mcycle_sel;
  assign bus.MCycleOp         = held.mcycle_op;
  assign bus.SizeSel          = held.size_sel;
  assign bus.Illegal          = held.illegal;
  assign bus.Rd               = held.rd;
  assign bus.Rs1              = held.rs1;
  assign bus.Rs2              = held.rs2;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: full build and
// a build with M and sub-word support disabled.
module tb_decode_stage;

  logic CLK;
  logic RESETn;

  int total = 0;
  int bad   = 0;

  decode_stage_if bus ();
  decode_stage_if bus0 ();

  decode_stage #(
    .M_EXT      (1),
    .SUBWORD_EN (1)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  decode_stage #(
    .M_EXT      (0),
    .SUBWORD_EN (0)
  ) dut0 (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [38:0] obs;
  logic [38:0] obs0;

  assign obs = {bus.PCS, bus.RegWrite,
    bus.MemWrite, bus.MemtoReg, bus.ALUSrcA,
    bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
    bus.ComputeResultSel, bus.MCycleResultSel,
    bus.MCycleOp, bus.SizeSel, bus.Illegal,
    bus.Rd, bus.Rs1, bus.Rs2};

  assign obs0 = {bus0.PCS, bus0.RegWrite,
    bus0.MemWrite, bus0.MemtoReg, bus0.ALUSrcA,
    bus0.ALUSrcB, bus0.ImmSrc, bus0.ALUControl,
    bus0.ComputeResultSel, bus0.MCycleResultSel,
    bus0.MCycleOp, bus0.SizeSel, bus0.Illegal,
    bus0.Rd, bus0.Rs1, bus0.Rs2};

  function automatic logic [38:0] model(
    input logic [31:0] i,
    input bit          mx,
    input bit          sw
  );
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] pcs, sa, sb, mop;
    logic       rw, mw, mr, crs, mrs, ill;
    logic [2:0] imm, sz;
    logic [3:0] alu;
    op = i[6:0];
    f3 = i[14:12];
    pcs = 0; sa = 0; sb = 0; mop = 0;
    rw = 0; mw = 0; mr = 0;
    crs = 0; mrs = 0; ill = 0;
    imm = 0; sz = 3'b010; alu = 0;
    case (op)
      7'h03:
        if (sw || f3 == 3'b010) begin
          rw = 1; mr = 1; sb = 3;
          imm = 3; sz = f3;
        end else ill = 1;
      7'h23:
        if (sw || f3 == 3'b010) begin
          mw = 1; sb = 3;
          imm = 6; sz = f3;
        end else ill = 1;
      7'h13: begin
        rw = 1; sb = 3; imm = 3;
        alu = (f3[1:0] == 2'b01) ?
              {f3, i[30]} : {f3, 1'b0};
      end
      7'h33:
        if (i[31:25] == 7'h01) begin
          if (mx) begin
            rw = 1; crs = 1;
            alu = {f3, 1'b0};
            case (f3)
              3'd0, 3'd1: mop = 2'b00;
              3'd2, 3'd3: mop = 2'b01;
              3'd4, 3'd6: mop = 2'b10;
              default:    mop = 2'b11;
            endcase
            mrs = !(f3 == 0 || f3 == 4 ||
                    f3 == 5);
          end else ill = 1;
        end else begin
          rw = 1;
          alu = {f3, i[30]};
        end
      7'h63: begin
        pcs = 1; imm = 7; alu = 1;
      end
      7'h6F: begin
        pcs = 2; rw = 1; imm = 2;
        sa = 3; sb = 1;
      end
      7'h67: begin
        pcs = 3; rw = 1; imm = 3;
        sa = 3; sb = 1;
      end
      7'h17: begin
        rw = 1; sa = 3; sb = 3;
      end
      7'h37: begin
        rw = 1; sa = 1; sb = 3;
      end
      default: ill = 1;
    endcase
    return {pcs, rw, mw, mr, sa, sb, imm,
            alu, crs, mrs, mop, sz, ill,
            i[11:7], i[19:15], i[24:20]};
  endfunction

  logic [38:0] sb_q[$];
  logic [38:0] exp_v;

  // Scoreboard: push on accept, pop on transfer
  always @(negedge CLK) begin
    if (!RESETn) begin
      sb_q.delete();
    end else begin
      if (bus.OutValid && bus.OutReady) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h",
                   obs);
        end else begin
          exp_v = sb_q.pop_front();
          if (obs !== exp_v) begin
            bad++;
            $display("FAIL sb_bundle got=%h want=%h",
                     obs, exp_v);
          end
        end
      end else if (bus.OutValid && bus.Flush &&
                   sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      if (bus.InValid && bus.InReady)
        sb_q.push_back(model(bus.InstrIn, 1, 1));
    end
  end

  task automatic send(input logic [31:0] ins);
    int n;
    n = 0;
    bus.InstrIn = ins;
    bus.InValid = 1'b1;
    @(negedge CLK);
    while (!bus.InReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (!bus.InReady) begin
      bad++;
      $display("FAIL send_timeout got=%0d want=<50",
               n);
    end
    @(posedge CLK); #1;
    bus.InValid = 1'b0;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b want=0",
               bus.OutValid);
    end
    total++;
    if (obs !== 39'd0) begin
      bad++;
      $display("FAIL rst_bundle got=%h want=0",
               obs);
    end
    total++;
    if (bus.MCycleStart !== 1'b0) begin
      bad++;
      $display("FAIL rst_mcstart got=%b want=0",
               bus.MCycleStart);
    end
    @(posedge CLK); #1;
    RESETn = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b want=1",
               bus.InReady);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_add();
    bus.OutReady = 1'b1;
    send(32'h002081B3);
    @(negedge CLK);
    total++;
    if (bus.OutValid !== 1'b1) begin
      bad++;
      $display("FAIL add_valid got=%b want=1",
               bus.OutValid);
    end
    total++;
    if (bus.RegWrite !== 1'b1) begin
      bad++;
      $display("FAIL add_rw got=%b want=1",
               bus.RegWrite);
    end
    total++;
    if (bus.ALUControl !== 4'b0000) begin
      bad++;
      $display("FAIL add_alu got=%b want=0000",
               bus.ALUControl);
    end
    total++;
    if (bus.ALUSrcB !== 2'b00) begin
      bad++;
      $display("FAIL add_srcb got=%b want=00",
               bus.ALUSrcB);
    end
    total++;
    if (bus.Rd !== 5'd3) begin
      bad++;
      $display("FAIL add_rd got=%0d want=3",
               bus.Rd);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [12];
    prog = '{32'h00500093, 32'h4030D113,
             32'h0020A223, 32'h00208463,
             32'h010000EF, 32'h123452B7,
             32'h00001317, 32'h00008067,
             32'h00008383, 32'h00209123,
             32'h0000007F, 32'h40208533};
    bus.OutReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.InstrIn = prog[k];
      bus.InValid = 1'b1;
      @(negedge CLK);
      total++;
      if (bus.InReady !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready[%0d] got=%b want=1",
                 k, bus.InReady);
      end
      @(posedge CLK); #1;
    end
    bus.InValid = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  task automatic test_stall();
    logic [38:0] snap;
    bus.OutReady = 1'b0;
    send(32'h00812203);
    bus.InstrIn = 32'h00100493;
    bus.InValid = 1'b1;
    @(negedge CLK);
    snap = obs;
    repeat (3) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      total++;
      if (obs !== snap || bus.OutValid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold got=%h want=%h",
                 obs, snap);
      end
      total++;
      if (bus.InReady !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready got=%b want=0",
                 bus.InReady);
      end
    end
    @(posedge CLK); #1;
    bus.OutReady = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got=%b want=1",
               bus.InReady);
    end
    @(posedge CLK); #1;
    bus.InValid = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.OutValid !== 1'b1 || bus.Rd !== 5'd9) begin
      bad++;
      $display("FAIL stall_next got=%b/%0d want=1/9",
               bus.OutValid, bus.Rd);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_mulhu();
    bus.OutReady   = 1'b1;
    bus.MCycleBusy = 1'b0;
    send(32'h027332B3);
    @(negedge CLK);
    total++;
    if (bus.MCycleOp !== 2'b01 ||
        bus.MCycleResultSel !== 1'b1 ||
        bus.ComputeResultSel !== 1'b1) begin
      bad++;
      $display("FAIL mul_fields got=%b%b%b want=0111",
               bus.MCycleOp, bus.MCycleResultSel,
               bus.ComputeResultSel);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (bus.MCycleStart !== 1'b1 ||
        bus.InReady !== 1'b0) begin
      bad++;
      $display("FAIL mul_start got=%b%b want=10",
               bus.MCycleStart, bus.InReady);
    end
    @(posedge CLK); #1;
    bus.MCycleBusy = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      total++;
      if (bus.MCycleStart !== 1'b0 ||
          bus.InReady !== 1'b0) begin
        bad++;
        $display("FAIL mul_wait got=%b%b want=00",
                 bus.MCycleStart, bus.InReady);
      end
      @(posedge CLK); #1;
    end
    bus.MCycleBusy = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b0) begin
      bad++;
      $display("FAIL mul_lastwait got=%b want=0",
               bus.InReady);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b1) begin
      bad++;
      $display("FAIL mul_run got=%b want=1",
               bus.InReady);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_flush();
    bus.OutReady = 1'b0;
    send(32'h00500093);
    bus.InstrIn = 32'h002081B3;
    bus.InValid = 1'b1;
    bus.Flush   = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b0) begin
      bad++;
      $display("FAIL flush_block got=%b want=0",
               bus.InReady);
    end
    @(posedge CLK); #1;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.OutValid !== 1'b0 || bus.Rd !== 5'd1) begin
      bad++;
      $display("FAIL flush_clear got=%b/%0d want=0/1",
               bus.OutValid, bus.Rd);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL flush_queue got=%0d want=0",
               sb_q.size());
    end
    @(posedge CLK); #1;
    bus.OutReady = 1'b1;
    send(32'h002081B3);
    bus.Flush = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    bus.Flush = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.OutValid !== 1'b0) begin
      bad++;
      $display("FAIL flush_xfer got=%b want=0",
               bus.OutValid);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_disabled();
    logic [31:0] ins [4];
    logic        ill [4];
    ins = '{32'h023100B3, 32'h0000007F,
            32'h00009203, 32'h00812203};
    ill = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus0.OutReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus0.InstrIn = ins[k];
      bus0.InValid = 1'b1;
      @(posedge CLK); #1;
      bus0.InValid = 1'b0;
      @(negedge CLK);
      total++;
      if (bus0.OutValid !== 1'b1 ||
          bus0.Illegal !== ill[k]) begin
        bad++;
        $display("FAIL dis_ill[%0d] got=%b%b want=1%b",
                 k, bus0.OutValid, bus0.Illegal,
                 ill[k]);
      end
      total++;
      if (obs0 !== model(ins[k], 0, 0)) begin
        bad++;
        $display("FAIL dis_bundle[%0d] got=%h want=%h",
                 k, obs0, model(ins[k], 0, 0));
      end
      @(posedge CLK); #1;
      @(negedge CLK);
      total++;
      if (bus0.MCycleStart !== 1'b0 ||
          bus0.InReady !== 1'b1) begin
        bad++;
        $display("FAIL dis_nomc[%0d] got=%b%b want=01",
                 k, bus0.MCycleStart, bus0.InReady);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mcwait();
    bus.OutReady   = 1'b1;
    bus.MCycleBusy = 1'b0;
    send(32'h027332B3);
    @(posedge CLK); #1;
    bus.MCycleBusy = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b0) begin
      bad++;
      $display("FAIL rmc_wait got=%b want=0",
               bus.InReady);
    end
    @(posedge CLK); #1;
    RESETn = 1'b0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.InReady !== 1'b1 ||
        bus.OutValid !== 1'b0 ||
        bus.MCycleStart !== 1'b0) begin
      bad++;
      $display("FAIL rmc_run got=%b%b%b want=100",
               bus.InReady, bus.OutValid,
               bus.MCycleStart);
    end
    @(posedge CLK); #1;
    bus.MCycleBusy = 1'b0;
  endtask

  initial begin
    RESETn          = 1'b0;
    bus.InstrIn     = '0;
    bus.InValid     = 1'b0;
    bus.OutReady    = 1'b0;
    bus.Flush       = 1'b0;
    bus.MCycleBusy  = 1'b0;
    bus0.InstrIn    = '0;
    bus0.InValid    = 1'b0;
    bus0.OutReady   = 1'b0;
    bus0.Flush      = 1'b0;
    bus0.MCycleBusy = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_mulhu();
    test_flush();
    test_disabled();
    test_reset_mcwait();
    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
